// File: rtl/data_mem_lsu.sv
// Word-organised data memory with an RV32I-style load/store unit.
// Requests are accepted on a valid/ready handshake and answered with a
// one-cycle response strobe; an optional post-reset sweep zeroes storage.
module data_mem_lsu #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [31:0]           init_data,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [31:0]           debug_data
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int IW    = ADDR_WIDTH - 2;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_clr_idx, w_clr_idx_nxt;
    logic            r_post_rst;
    logic [31:0]     r_mem [DEPTH];

    logic [IW-1:0]   w_idx;
    logic [1:0]      w_off;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_misal;
    logic            w_f3_bad;
    logic            w_err;
    logic            w_accept;
    logic            w_init_wr;
    logic            w_store_wr;
    logic [31:0]     w_load_data;
    logic [3:0]      w_wmask;
    logic [31:0]     w_wlanes;
    logic [31:0]     w_store_word;
    logic            w_unused;

    // Low address bits of word-granular ports carry no information.
    assign w_unused = ^{init_addr[1:0], debug_addr[1:0]};

    // The extra post-reset cycle keeps ready low right after reset even
    // when the sweep is disabled and the FSM lands directly in IDLE.
    assign req_ready  = (r_state == S_IDLE) && !init_we && !r_post_rst;
    assign w_accept   = req_valid && req_ready && !rst;
    assign w_init_wr  = init_we && (r_state == S_IDLE) && !rst;
    assign w_store_wr = w_accept && req_we && !w_err;
    assign debug_data = r_mem[debug_addr[ADDR_WIDTH-1:2]];

    // FSM next state: sweep word indices, leave CLEAR after the last word
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        if (r_state == S_CLEAR) begin
            w_clr_idx_nxt = r_clr_idx + 1'b1;
            if (&r_clr_idx) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // FSM state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            r_clr_idx  <= '0;
            r_post_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_idx  <= w_clr_idx_nxt;
            r_post_rst <= 1'b0;
        end
    end

    // Request decode: alignment, legality, load extension, store merge
    always_comb begin
        w_idx    = req_addr[ADDR_WIDTH-1:2];
        w_off    = req_addr[1:0];
        w_word   = r_mem[w_idx];
        w_byte   = w_word[{w_off, 3'b000} +: 8];
        w_half   = w_word[{w_off[1], 4'b0000} +: 16];
        w_misal  = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_f3_bad = req_we ? (req_func3 > 3'b010)
                          : ((req_func3 == 3'b011) || (req_func3[2:1] == 2'b11));
        w_err    = w_misal || w_f3_bad;

        w_load_data = '0;
        case (req_func3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'h0, w_half};
            3'b010:  w_load_data = w_word;
            default: w_load_data = '0;
        endcase

        w_wmask  = '0;
        w_wlanes = req_wdata;
        case (req_func3)
            3'b000: begin
                w_wmask  = 4'b0001 << w_off;
                w_wlanes = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                w_wmask  = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                w_wmask  = '1;
                w_wlanes = req_wdata;
            end
            default: w_wmask = '0;
        endcase

        w_store_word = w_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_wmask[i]) begin
                w_store_word[8*i +: 8] = w_wlanes[8*i +: 8];
            end
        end
    end

    // Storage write port: sweep, then loader, then accepted stores
    always_ff @(posedge clk) begin
        if ((r_state == S_CLEAR) && !rst) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_init_wr) begin
            r_mem[init_addr[ADDR_WIDTH-1:2]] <= init_data;
        end else if (w_store_wr) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    // Response register: one strobe per acceptance, data held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= w_accept;
            if (w_accept) begin
                rsp_err   <= w_err;
                rsp_rdata <= (req_we || w_err) ? '0 : w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a 16-word memory.
module tb_data_mem_lsu;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_func3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [31:0]   init_data;
    logic [AW-1:0] debug_addr;
    logic [31:0]   debug_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .debug_addr (debug_addr),
        .debug_data (debug_data)
    );

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from posedge+1 and captures the observed handshake.
    task automatic send(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wd, output logic rdy, output logic v1,
                        output logic e1, output logic [31:0] d1, output logic v2,
                        output logic [31:0] d2);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        rdy = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        v1 = rsp_valid;
        e1 = rsp_err;
        d1 = rsp_rdata;
        @(posedge clk);
        #1;
        v2 = rsp_valid;
        d2 = rsp_rdata;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        sync();
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got=%h exp=00000000", rsp_rdata); end
        cnt = 0;
        for (int i = 0; i < 40 && req_ready !== 1'b1; i++) begin
            cnt++;
            sync();
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL rst_clear_cycles got=%0d exp=16", cnt); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", req_ready); end
        for (int w = 0; w < 16; w++) begin
            debug_addr = AW'(w * 4);
            #1;
            checks++; if (debug_data !== 32'h0) begin errors++; $display("FAIL rst_dbg_word%0d got=%h exp=00000000", w, debug_data); end
        end
        sync();
    endtask

    task automatic test_loads();
        logic [2:0]    f3s [6];
        logic [AW-1:0] ads [6];
        logic [31:0]   exps [6];
        logic rdy, v1, e1, v2;
        logic [31:0] d1, d2;
        f3s  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        ads  = '{6'h0C, 6'h0E, 6'h0E, 6'h0E, 6'h0E, 6'h0C};
        exps = '{32'h00000001, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        init_we   = 1'b1;
        init_addr = 6'h0C;
        init_data = 32'h80FF7F01;
        sync();
        init_we = 1'b0;
        debug_addr = 6'h0C;
        #1;
        checks++; if (debug_data !== 32'h80FF7F01) begin errors++; $display("FAIL init_dbg got=%h exp=80FF7F01", debug_data); end
        sync();
        for (int i = 0; i < 6; i++) begin
            send(1'b0, f3s[i], ads[i], 32'h0, rdy, v1, e1, d1, v2, d2);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL load%0d_ready got=%b exp=1", i, rdy); end
            checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL load%0d_valid got=%b exp=1", i, v1); end
            checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL load%0d_err got=%b exp=0", i, e1); end
            checks++; if (d1 !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got=%h exp=%h", i, d1, exps[i]); end
            checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL load%0d_single_strobe got=%b exp=0", i, v2); end
            checks++; if (d2 !== exps[i]) begin errors++; $display("FAIL load%0d_hold got=%h exp=%h", i, d2, exps[i]); end
        end
    endtask

    task automatic test_stores();
        logic [2:0]    f3s [3];
        logic [AW-1:0] ads [3];
        logic [31:0]   wds [3];
        logic rdy, v1, e1, v2;
        logic [31:0] d1, d2;
        f3s = '{3'b010, 3'b000, 3'b001};
        ads = '{6'h08, 6'h09, 6'h0A};
        wds = '{32'h11223344, 32'h000000AA, 32'h0000BEEF};
        for (int i = 0; i < 3; i++) begin
            send(1'b1, f3s[i], ads[i], wds[i], rdy, v1, e1, d1, v2, d2);
            checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL store%0d_valid got=%b exp=1", i, v1); end
            checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL store%0d_err got=%b exp=0", i, e1); end
            checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL store%0d_rdata got=%h exp=00000000", i, d1); end
        end
        debug_addr = 6'h08;
        #1;
        checks++; if (debug_data !== 32'hBEEFAA44) begin errors++; $display("FAIL store_dbg got=%h exp=BEEFAA44", debug_data); end
        sync();
        send(1'b0, 3'b010, 6'h08, 32'h0, rdy, v1, e1, d1, v2, d2);
        checks++; if (d1 !== 32'hBEEFAA44) begin errors++; $display("FAIL store_lw got=%h exp=BEEFAA44", d1); end
    endtask

    task automatic test_errors();
        logic          wes [5];
        logic [2:0]    f3s [5];
        logic [AW-1:0] ads [5];
        logic rdy, v1, e1, v2;
        logic [31:0] d1, d2;
        wes = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        f3s = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
        ads = '{6'h03, 6'h06, 6'h08, 6'h08, 6'h09};
        for (int i = 0; i < 5; i++) begin
            send(wes[i], f3s[i], ads[i], 32'h5555_55FF, rdy, v1, e1, d1, v2, d2);
            checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL err%0d_valid got=%b exp=1", i, v1); end
            checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL err%0d_err got=%b exp=1", i, e1); end
            checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%h exp=00000000", i, d1); end
        end
        debug_addr = 6'h08;
        #1;
        checks++; if (debug_data !== 32'hBEEFAA44) begin errors++; $display("FAIL err_mem08 got=%h exp=BEEFAA44", debug_data); end
        debug_addr = 6'h04;
        #1;
        checks++; if (debug_data !== 32'h0) begin errors++; $display("FAIL err_mem04 got=%h exp=00000000", debug_data); end
        sync();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 6'h10;
        req_wdata = 32'hCAFEBABE;
        sync();
        req_we    = 1'b0;
        req_wdata = 32'h0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_store_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_store_rdata got=%h exp=00000000", rsp_rdata); end
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        sync();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_load_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL b2b_load_rdata got=%h exp=CAFEBABE", rsp_rdata); end
        sync();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_init_priority();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 6'h0C;
        init_we   = 1'b1;
        init_addr = 6'h14;
        init_data = 32'h12345678;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_low got=%b exp=0", req_ready); end
        @(posedge clk);
        #1;
        init_we = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL prio_no_accept got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_high got=%b exp=1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL prio_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h80FF7F01) begin errors++; $display("FAIL prio_rsp_rdata got=%h exp=80FF7F01", rsp_rdata); end
        debug_addr = 6'h14;
        #1;
        checks++; if (debug_data !== 32'h12345678) begin errors++; $display("FAIL prio_init_dbg got=%h exp=12345678", debug_data); end
        sync();
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 6'h0C;
        rst       = 1'b1;
        sync();
        rst       = 1'b0;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drop_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL drop_rsp_rdata got=%h exp=00000000", rsp_rdata); end
        repeat (5) sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && req_ready !== 1'b1; i++) begin
            cnt++;
            sync();
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL restart_clear_cycles got=%0d exp=16", cnt); end
        debug_addr = 6'h0C;
        #1;
        checks++; if (debug_data !== 32'h0) begin errors++; $display("FAIL restart_mem0C got=%h exp=00000000", debug_data); end
        debug_addr = 6'h3C;
        #1;
        checks++; if (debug_data !== 32'h0) begin errors++; $display("FAIL restart_mem3C got=%h exp=00000000", debug_data); end
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_func3  = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        init_we    = 1'b0;
        init_addr  = '0;
        init_data  = '0;
        debug_addr = '0;
        sync();
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_init_priority();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte-address width; word depth DEPTH = 2**(ADDR_WIDTH-2).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-sweep all words after reset, 0 = skip sweep.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 Request ports:
- req_valid in 1, request present.
- req_ready out 1, request accepted when high with req_valid.
- req_we in 1, 1 = store, 0 = load.
- req_func3 in 3, RV32I funct3 width code.
- req_addr in ADDR_WIDTH, byte address.
- req_wdata in 32, store data in the low lanes.
REQ-005 Response ports:
- rsp_valid out 1, one-cycle response strobe.
- rsp_rdata out 32, extended load data; 0 for stores and errors.
- rsp_err out 1, misaligned access or illegal func3.
REQ-006 Init ports:
- init_we in 1, testbench/loader word write.
- init_addr in ADDR_WIDTH, byte address; bits [1:0] ignored.
- init_data in 32, word to write.
REQ-007 Debug ports: debug_addr in ADDR_WIDTH, byte address; debug_data out 32, combinational word read at debug_addr[ADDR_WIDTH-1:2].

Function
REQ-008 SHALL have FSM states CLEAR and IDLE; storage is DEPTH x 32 bit, little-endian byte lanes.
REQ-009 CLEAR: writes 0 to word index clr_idx each cycle, counting 0..DEPTH-1; after writing DEPTH-1, goes to IDLE on the next edge. CLEAR takes exactly DEPTH cycles.
REQ-010 In IDLE, req_ready SHALL = !init_we; in CLEAR, req_ready SHALL be 0 and init_we SHALL be ignored.
REQ-011 init_we in IDLE SHALL write init_data to word init_addr[ADDR_WIDTH-1:2] at the clock edge; init has priority over requests.
REQ-012 Acceptance at edge N SHALL produce exactly one response: rsp_valid=1 during cycle N+1 only. Back-to-back acceptance allowed, giving one response per cycle.
REQ-013 Alignment: func3 000/100 is always aligned; 001/101 requires addr[0]=0; 010 requires addr[1:0]=00.
REQ-014 Loads:
- 000 LB: sign-extend the selected byte.
- 100 LBU: zero-extend the selected byte.
- 001 LH: sign-extend the selected halfword.
- 101 LHU: zero-extend the selected halfword.
- 010 LW: return the whole word.
- Lane selection by addr[1:0].
REQ-015 Stores:
- 000 SB: write req_wdata[7:0] to byte lane addr[1:0].
- 001 SH: write req_wdata[15:0] to lanes addr[1]*2 +1:+0.
- 010 SW: write the whole word.
- Unselected lanes SHALL be preserved.
REQ-016 Errors: misalignment, load func3 011/110/111, or store func3 other than 000/001/010 SHALL give rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-017 Load data SHALL reflect memory contents before any store accepted in the same edge; a load accepted the edge after a store to the same word SHALL see the new data.
REQ-018 debug_data SHALL be combinational and reflect writes from the preceding edge.
REQ-019 rsp_rdata SHALL hold its value when rsp_valid=0; only rsp_valid is qualifying.

Reset
REQ-020 rst=1 at an edge SHALL force: state=CLEAR (IDLE if CLEAR_ON_RESET=0), clr_idx=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 in the following cycle.
REQ-021 rst asserted mid-CLEAR SHALL restart the sweep from index 0; rst asserted with a response pending SHALL drop that response.
REQ-022 With CLEAR_ON_RESET=0, memory contents SHALL be retained across rst.

Verification
REQ-023 Reset with ADDR_WIDTH=6: rst for 1 cycle -> req_ready=0 for exactly 16 cycles, then 1; debug reads of all 16 words return 00000000.
REQ-024 init_we writes 0x0C <- 80FF7F01, then LB 0x0C -> 00000001; LB 0x0E -> FFFFFFFF; LBU 0x0E -> 000000FF; LH 0x0E -> FFFF80FF; LHU 0x0E -> 000080FF; LW 0x0C -> 80FF7F01; each with rsp_valid one cycle after acceptance.
REQ-025 SW 0x08 <- 11223344, SB 0x09 <- AA, SH 0x0A <- BEEF -> debug_data at 0x08 = BEEFAA44, then LW 0x08 = BEEFAA44.
REQ-026 LH at 0x03, LW at 0x06, load func3 011, SB with func3 100 -> each gives rsp_err=1 and rsp_rdata=0; memory is unchanged (checked by debug port).
REQ-027 req_valid held high while init_we pulses -> req_ready=0 that cycle and the request is accepted next cycle. rst asserted at clr_idx=5 -> the sweep restarts and IDLE is reached DEPTH cycles after rst deasserts.
